// File: rtl/lsu_if.sv
// LSU bundle: execute-stage input, data-memory request/response bus, write-back output.
// Latency: none; wiring only. The out_misalign field exists only when LSU_MISALIGN_CHECK_EN is defined.
// Backpressure: in_valid/in_ready, mem_req_valid/mem_req_ready and out_valid/out_ready handshakes.
interface lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] alu_result;
    logic [DATA_W-1:0] rsb;
    logic              ren;
    logic              wen;
    logic [7:0]        wmask;
    logic [DATA_W-1:0] rmask;
    logic              memory_read_signed;
    logic [4:0]        rd;
    logic              reg_write_en;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_wen;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [7:0]        mem_req_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_rdata;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [4:0]        out_rd;
    logic              out_reg_write_en;
`ifdef LSU_MISALIGN_CHECK_EN
    logic              out_misalign;
`endif

    // LSU side
    modport slave (
        input  in_valid, alu_result, rsb, ren, wen, wmask, rmask,
               memory_read_signed, rd, reg_write_en,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
        input  out_ready,
        output in_ready,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        output out_valid, out_data, out_rd, out_reg_write_en
`ifdef LSU_MISALIGN_CHECK_EN
        , output out_misalign
`endif
    );

    // Environment side: execute stage, memory and write-back stage
    modport master (
        output in_valid, alu_result, rsb, ren, wen, wmask, rmask,
               memory_read_signed, rd, reg_write_en,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata,
        output out_ready,
        input  in_ready,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        input  out_valid, out_data, out_rd, out_reg_write_en
`ifdef LSU_MISALIGN_CHECK_EN
        , input out_misalign
`endif
    );
endinterface

// File: rtl/lsu.sv
// Memory-access stage: one execute result in, at most one memory access, one write-back packet out.
// Latency: non-memory 1 cycle; memory 3 cycles with zero-wait request and next-cycle response.
// Backpressure: non-pipelined; in_ready only in IDLE, packet held in DONE until out_ready. Optional LSU_MISALIGN_CHECK_EN.
module lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  lsu_bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [DATA_W-1:0] MASK_B = {{(DATA_W-8){1'b0}}, 8'hFF};
    localparam logic [DATA_W-1:0] MASK_H = {{(DATA_W-16){1'b0}}, 16'hFFFF};
    localparam logic [DATA_W-1:0] MASK_W = '1;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [7:0]        r_wmask;
    logic              r_wen;
    logic [DATA_W-1:0] r_rmask;
    logic              r_signed;
    logic [4:0]        r_rd;
    logic              r_rwe;
    logic [DATA_W-1:0] r_data;

    logic [DATA_W-1:0] w_masked;
    logic [DATA_W-1:0] w_load;
    logic              w_mem;

`ifdef LSU_MISALIGN_CHECK_EN
    logic r_misalign;
    logic w_half;
    logic w_word;
    logic w_misalign;

    // Alignment check on the incoming packet; a store's width comes from wmask, a load's from rmask
    always_comb begin
        w_half     = lsu_bus.wen ? (lsu_bus.wmask == 8'h03) : (lsu_bus.rmask == MASK_H);
        w_word     = lsu_bus.wen ? (lsu_bus.wmask == 8'h0F) : (lsu_bus.rmask == MASK_W);
        w_misalign = (lsu_bus.ren | lsu_bus.wen) &
                     ((w_half & lsu_bus.alu_result[0]) | (w_word & (|lsu_bus.alu_result[1:0])));
    end

    assign lsu_bus.out_misalign = r_misalign;
`endif

    assign w_mem = lsu_bus.ren | lsu_bus.wen;

    // Load data: mask, then sign-extend from the top bit of a byte or halfword mask
    always_comb begin
        w_masked = lsu_bus.mem_resp_rdata & r_rmask;
        w_load   = w_masked;
        if (r_signed) begin
            if (r_rmask == MASK_B) begin
                w_load = {{(DATA_W-8){w_masked[7]}}, w_masked[7:0]};
            end else if (r_rmask == MASK_H) begin
                w_load = {{(DATA_W-16){w_masked[15]}}, w_masked[15:0]};
            end
        end
    end

    // Control FSM and packet registers; one instruction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wmask  <= '0;
            r_wen    <= 1'b0;
            r_rmask  <= '0;
            r_signed <= 1'b0;
            r_rd     <= '0;
            r_rwe    <= 1'b0;
            r_data   <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (lsu_bus.in_valid) begin
                        r_addr   <= lsu_bus.alu_result;
                        r_wdata  <= lsu_bus.rsb;
                        r_wmask  <= lsu_bus.wmask;
                        r_wen    <= lsu_bus.wen;
                        r_rmask  <= lsu_bus.rmask;
                        r_signed <= lsu_bus.memory_read_signed;
                        r_rd     <= lsu_bus.rd;
                        r_rwe    <= lsu_bus.reg_write_en;
                        r_data   <= DATA_W'(lsu_bus.alu_result);
                        r_state  <= w_mem ? S_REQ : S_DONE;
`ifdef LSU_MISALIGN_CHECK_EN
                        // Misaligned access never reaches memory and must not write a register
                        if (w_misalign) begin
                            r_state    <= S_DONE;
                            r_rwe      <= 1'b0;
                            r_misalign <= 1'b1;
                        end
`endif
                    end
                end
                S_REQ: begin
                    if (lsu_bus.mem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lsu_bus.mem_resp_valid) begin
                        // Stores (including ren+wen) keep alu_result as write-back data
                        if (!r_wen) begin
                            r_data <= w_load;
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (lsu_bus.out_ready) begin
                        r_state <= S_IDLE;
`ifdef LSU_MISALIGN_CHECK_EN
                        r_misalign <= 1'b0;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign lsu_bus.in_ready         = (r_state == S_IDLE);
    assign lsu_bus.mem_req_valid    = (r_state == S_REQ);
    assign lsu_bus.mem_req_addr     = r_addr;
    assign lsu_bus.mem_req_wen      = r_wen;
    assign lsu_bus.mem_req_wdata    = r_wdata;
    assign lsu_bus.mem_req_wmask    = r_wmask;
    assign lsu_bus.out_valid        = (r_state == S_DONE);
    assign lsu_bus.out_data         = r_data;
    assign lsu_bus.out_rd           = r_rd;
    assign lsu_bus.out_reg_write_en = r_rwe;
endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: directed packets, responding memory model, scoreboard-checked outputs.
// Latency: checks in-to-out latency from the accept cycle to the first out_valid cycle.
// Backpressure: exercises request stalls, write-back stalls and reset while waiting for memory.
module tb_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_if bus ();
    lsu dut (.clk(clk), .rst(rst), .lsu_bus(bus));

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rwe;
        logic        mis;
        int          lat;
    } out_t;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [7:0]  wmask;
        int          cycles;
    } req_t;

    out_t out_q[$];
    req_t req_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int req_cnt = 0;
    logic prev_req = 1'b0;
    logic prev_out = 1'b0;
    logic prev_hs  = 1'b0;

    int          req_stall   = 0;
    logic [31:0] resp_data   = '0;
    logic        no_resp     = 1'b0;
    logic        inject_resp = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic fail_msg(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    // Memory model: stalls ready for req_stall cycles, answers one cycle after the handshake
    initial begin
        int   scnt;
        logic active;
        logic pending;
        scnt = 0;
        active = 1'b0;
        pending = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_resp_valid = 1'b0;
            if (pending || inject_resp) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_rdata = resp_data;
            end
            pending = 1'b0;
            if (bus.mem_req_valid && !rst) begin
                if (!active) begin
                    active = 1'b1;
                    scnt = req_stall;
                end
                if (scnt > 0) begin
                    bus.mem_req_ready = 1'b0;
                    scnt--;
                end else begin
                    bus.mem_req_ready = 1'b1;
                    active = 1'b0;
                    pending = !no_resp;
                end
            end else begin
                bus.mem_req_ready = 1'b0;
                active = 1'b0;
            end
        end
    end

    // Monitor: compares requests and write-back packets against the scoreboard queues
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (bus.in_valid && bus.in_ready) acc_cyc = cyc;

                if (bus.mem_req_valid) begin
                    if (req_q.size() == 0) begin
                        fail_msg("unexpected_mem_req");
                    end else begin
                        chk("req_addr",  bus.mem_req_addr,  req_q[0].addr);
                        chk("req_wen",   32'(bus.mem_req_wen), 32'(req_q[0].wen));
                        chk("req_wdata", bus.mem_req_wdata, req_q[0].wdata);
                        chk("req_wmask", 32'(bus.mem_req_wmask), 32'(req_q[0].wmask));
                        req_cnt++;
                    end
                end else if (prev_req && req_q.size() > 0) begin
                    chk("req_cycles", req_cnt, req_q[0].cycles);
                    void'(req_q.pop_front());
                    req_cnt = 0;
                end
                prev_req = bus.mem_req_valid;

                if (prev_hs) begin
                    chk("idle_after_out", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
                end

                if (bus.out_valid) begin
                    if (out_q.size() == 0) begin
                        fail_msg("unexpected_out_valid");
                    end else begin
                        if (!prev_out) chk("latency", cyc - acc_cyc, out_q[0].lat);
                        chk("out_data", bus.out_data, out_q[0].data);
                        chk("out_rd",   32'(bus.out_rd), 32'(out_q[0].rd));
                        chk("out_rwe",  32'(bus.out_reg_write_en), 32'(out_q[0].rwe));
`ifdef LSU_MISALIGN_CHECK_EN
                        chk("out_misalign", 32'(bus.out_misalign), 32'(out_q[0].mis));
`endif
                        chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
                        if (bus.out_ready) void'(out_q.pop_front());
                    end
                end
                prev_out = bus.out_valid;
                prev_hs  = bus.out_valid && bus.out_ready;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) fail_msg("timeout_wait_idle");
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!(out_q.size() == 0 && req_q.size() == 0 && bus.in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_msg("timeout_wait_done");
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] rs, input logic r, input logic w,
                         input logic [7:0] wm, input logic [31:0] rm, input logic sg,
                         input logic [4:0] d, input logic rwe_i, input logic [31:0] rdata,
                         input int stall, input logic exp_out, input logic [31:0] exp_data,
                         input logic exp_rwe, input logic exp_mis, input int lat);
        out_t o;
        req_t q;
        wait_idle();
        o = '{data: exp_data, rd: d, rwe: exp_rwe, mis: exp_mis, lat: lat};
        q = '{addr: a, wen: w, wdata: rs, wmask: wm, cycles: stall + 1};
        if (exp_out) out_q.push_back(o);
        if ((r || w) && !exp_mis) req_q.push_back(q);
        req_stall = stall;
        resp_data = rdata;
        @(posedge clk); #1;
        bus.alu_result = a;
        bus.rsb = rs;
        bus.ren = r;
        bus.wen = w;
        bus.wmask = wm;
        bus.rmask = rm;
        bus.memory_read_signed = sg;
        bus.rd = d;
        bus.reg_write_en = rwe_i;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.alu_result = '0;
        bus.rsb = '0;
        bus.ren = 1'b0;
        bus.wen = 1'b0;
        bus.wmask = '0;
        bus.rmask = '0;
        bus.memory_read_signed = 1'b0;
        bus.rd = '0;
        bus.reg_write_en = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_out_data",  bus.out_data, 32'd0);
        chk("rst_req_addr",  bus.mem_req_addr, 32'd0);

        // a, rsb, ren, wen, wmask, rmask, signed, rd, rwe, rdata, stall, exp_out, exp_data, exp_rwe, exp_mis, lat
        issue(32'h0000_0123, 32'h0, 0, 0, 8'h00, 32'h0, 0, 5'd5, 1, 32'h0, 0, 1, 32'h0000_0123, 1, 0, 1);
        wait_done();
        issue(32'h8000_0004, 32'h0, 1, 0, 8'h00, 32'h0000_00FF, 1, 5'd3, 1, 32'h0000_0080, 0, 1, 32'hFFFF_FF80, 1, 0, 3);
        wait_done();
        issue(32'h8000_0004, 32'h0, 1, 0, 8'h00, 32'h0000_00FF, 0, 5'd4, 1, 32'h0000_0080, 0, 1, 32'h0000_0080, 1, 0, 3);
        wait_done();
        issue(32'h1000_0008, 32'hDEAD_BEEF, 0, 1, 8'h0F, 32'h0, 0, 5'd9, 0, 32'h5555_5555, 3, 1, 32'h1000_0008, 0, 0, 6);
        wait_done();
        issue(32'h2000_0002, 32'h0, 1, 0, 8'h00, 32'h0000_FFFF, 1, 5'd10, 1, 32'h1234_8001, 0, 1, 32'hFFFF_8001, 1, 0, 3);
        wait_done();
        issue(32'h2000_0000, 32'h0, 1, 0, 8'h00, 32'hFFFF_FFFF, 1, 5'd11, 1, 32'h8765_4321, 0, 1, 32'h8765_4321, 1, 0, 3);
        wait_done();
        issue(32'h3000_0004, 32'hCAFE_F00D, 1, 1, 8'h0F, 32'hFFFF_FFFF, 1, 5'd12, 0, 32'h0000_0001, 0, 1, 32'h3000_0004, 0, 0, 3);
        wait_done();
        issue(32'h0000_0024, 32'h0, 1, 0, 8'h00, 32'h0000_0FFF, 1, 5'd14, 1, 32'hFFFF_FFFF, 0, 1, 32'h0000_0FFF, 1, 0, 3);
        wait_done();

        // Write-back stall: out_ready low for 5 cycles after out_valid rises
        bus.out_ready = 1'b0;
        issue(32'h2000_0006, 32'h0, 1, 0, 8'h00, 32'h0000_FFFF, 0, 5'd13, 1, 32'hABCD_EF12, 0, 1, 32'h0000_EF12, 1, 0, 3);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) fail_msg("timeout_out_valid");
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_done();

        // Reset while waiting for the memory response; a late response must be ignored
        no_resp = 1'b1;
        issue(32'h0000_0040, 32'h0, 1, 0, 8'h00, 32'h0000_00FF, 0, 5'd15, 1, 32'h0000_0077, 0, 0, 32'h0, 0, 0, 0);
        n = 0;
        while (req_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_q.size() != 0) fail_msg("timeout_reach_wait");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        inject_resp = 1'b1;
        @(posedge clk); #1;
        inject_resp = 1'b0;
        no_resp = 1'b0;
        repeat (3) @(negedge clk);
        chk("wrst_in_ready",  32'(bus.in_ready), 32'd1);
        chk("wrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("wrst_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("wrst_out_data",  bus.out_data, 32'd0);
        chk("wrst_out_rd",    32'(bus.out_rd), 32'd0);
        chk("wrst_out_rwe",   32'(bus.out_reg_write_en), 32'd0);
        chk("wrst_req_addr",  bus.mem_req_addr, 32'd0);

        // Recovery after reset
        issue(32'h0000_0ABC, 32'h0, 0, 0, 8'h00, 32'h0, 0, 5'd1, 1, 32'h0, 0, 1, 32'h0000_0ABC, 1, 0, 1);
        wait_done();

`ifdef LSU_MISALIGN_CHECK_EN
        issue(32'h8000_0002, 32'h0, 1, 0, 8'h00, 32'hFFFF_FFFF, 0, 5'd7, 1, 32'h0, 0, 1, 32'h8000_0002, 0, 1, 1);
        wait_done();
        chk("misalign_cleared", 32'(bus.out_misalign), 32'd0);
        issue(32'h8000_0001, 32'h1111_2222, 0, 1, 8'h03, 32'h0, 0, 5'd8, 1, 32'h0, 0, 1, 32'h8000_0001, 0, 1, 1);
        wait_done();
`endif

        chk("out_q_empty", out_q.size(), 32'd0);
        chk("req_q_empty", req_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Memory-access stage; the consumer end of the execute-stage valid/ready output.
- Accepts one execute result per transaction: ALU result, store data, load/store controls and write-back tags.
- Performs at most one data-memory access over a request/response bus, then hands one write-back packet to the write-back stage with a valid/ready handshake.
- Multi-cycle and non-pipelined: one instruction in flight.

Parameters:
ADDR_W, 32, memory address width; taken from alu_result.
DATA_W, 32, data width of store data, load data and write-back data.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  execute stage presents a packet
in_ready  out  1  LSU can accept a packet
alu_result  in  32  memory address for ren/wen; write-back value otherwise
rsb  in  32  store data
ren  in  1  load
wen  in  1  store
wmask  in  8  byte write mask, forwarded unchanged
rmask  in  32  load bit mask: 0x000000FF, 0x0000FFFF or 0xFFFFFFFF
memory_read_signed  in  1  sign-extend load data
rd  in  5  destination register
reg_write_en  in  1  register write enable, forwarded
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  32  request address
mem_req_wen  out  1  1 = write, 0 = read
mem_req_wdata  out  32  write data
mem_req_wmask  out  8  write mask
mem_resp_valid  in  1  response valid; always accepted in WAIT
mem_resp_rdata  in  32  read data, already aligned to bit 0 by the memory side
out_valid  out  1  write-back packet valid
out_ready  in  1  write-back stage accepts packet
out_data  out  32  write-back data
out_rd  out  5  destination register
out_reg_write_en  out  1  register write enable
out_misalign  out  1  misaligned-access flag; only when LSU_MISALIGN_CHECK_EN is defined

Behaviour:
- Reset: state = IDLE, all registered outputs = 0, in_ready = 1 in the cycle after reset.
- Reset mid-operation abandons any pending request. A mem_resp_valid that arrives later is ignored, because IDLE ignores responses.

States are IDLE, REQ, WAIT and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid, latch all inputs.
  - If ren or wen is set, go to REQ; otherwise go to DONE with data = alu_result.
- REQ:
  - mem_req_valid = 1.
  - addr = latched alu_result, mem_req_wen = latched wen, wdata = rsb, wmask = wmask.
  - On mem_req_ready, go to WAIT. Request fields stay stable while waiting for ready.
- WAIT:
  - On mem_resp_valid, go to DONE.
  - For a load, latch the processed rdata; for a store, ignore rdata and keep data = alu_result.
  - mem_resp_valid in the same cycle that REQ is left is not possible: a response is only valid from the cycle after the request handshake.
- DONE:
  - out_valid = 1; outputs are held stable until out_ready.
  - On out_ready, go to IDLE.
- in_ready = 0 in REQ, WAIT and DONE. No new packet is accepted in the same cycle as the out handshake.
- ren and wen both set: the store takes priority (mem_req_wen = 1); the packet is otherwise treated as a store.

Load processing:
- masked = rdata & rmask.
- If memory_read_signed, sign-extend from the top bit of the mask: bit 7 for 0xFF, bit 15 for 0xFFFF; 0xFFFFFFFF is unchanged.
- Any other rmask value: no extension, masked value only.

Latency, counting from the in handshake in cycle N:
- Non-memory packet: out_valid in N+1.
- Memory packet with mem_req_ready = 1 and response one cycle after the request: request in N+1, response in N+2, out_valid in N+3.

Optional Feature:
Macro: LSU_MISALIGN_CHECK_EN.
- Defined: at the in handshake the LSU computes misalignment.
  - Misaligned means a halfword access (rmask = 0xFFFF, or wmask = 0x03 for stores) with addr[0] set, or a word access (rmask = 0xFFFFFFFF, or wmask = 0x0F) with addr[1:0] nonzero.
  - A misaligned packet skips REQ/WAIT and goes directly to DONE.
  - out_misalign = 1, out_reg_write_en = 0, out_data = alu_result.
  - out_misalign clears on the out handshake.
- Undefined: the out_misalign port is absent and no check is made; every ren/wen packet issues a request.

Test Plan:
- Non-memory op: alu_result = 0x00000123, rd = 5, reg_write_en = 1, out_ready = 1 → out_valid one cycle after accept, out_data = 0x123, out_rd = 5; no mem_req_valid pulse.
- Signed byte load: addr 0x80000004, rmask = 0xFF, signed = 1, rdata = 0x00000080 → out_data = 0xFFFFFF80 in N+3; unsigned variant → 0x00000080.
- Store with backpressure: wen = 1, rsb = 0xDEADBEEF, wmask = 0x0F, mem_req_ready low for 3 cycles → mem_req_valid and all request fields stable for 4 cycles; out_data = alu_result after the response.
- Output stall: a load completes with out_ready = 0 for 5 cycles → out_valid held, out_data stable, in_ready = 0 throughout, then back to IDLE one cycle after out_ready.
- Reset in WAIT: assert rst one cycle, then pulse mem_resp_valid → no out_valid, in_ready = 1, all outputs 0.
- With LSU_MISALIGN_CHECK_EN: word load at 0x80000002 → no memory request, out_valid in N+1, out_misalign = 1, out_reg_write_en = 0.
